// File: rtl/result_dump.sv
// result_dump: walks the result RAM from address 0 to DEPTH-1
// and streams each 32-bit word, MSB byte first, as four 8N1 UART frames.
module result_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = $clog2(RD_LAT + 1);

  localparam logic [TW-1:0]     T_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0]     L_END = LW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] A_END = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [TW-1:0]     r_tmr;
  logic [LW-1:0]     r_lat;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte;
  logic [DATA_W-1:0] r_sh;
  logic [ADDR_W-1:0] r_addr;
  logic              r_tx;

  logic [7:0] w_cur;
  logic       w_tend;

  assign w_cur  = r_sh[DATA_W-1 -: 8];
  assign w_tend = (r_tmr == T_END);

  // Sequencer: fetch word, then four frames; tx is set at each transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_lat   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_sh    <= '0;
      r_addr  <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          r_tx   <= 1'b1;
          r_addr <= '0;
          if (start) begin
            r_lat   <= '0;
            r_state <= S_FETCH;
          end
        end
        (r_state == S_FETCH): begin
          if (r_lat == L_END) begin
            r_sh    <= ram_q;
            r_byte  <= '0;
            r_tmr   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        (r_state == S_START): begin
          if (w_tend) begin
            r_tmr   <= '0;
            r_bit   <= '0;
            r_tx    <= w_cur[0];
            r_state <= S_DATA;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        (r_state == S_DATA): begin
          if (w_tend) begin
            r_tmr <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= w_cur[r_bit + 3'd1];
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        (r_state == S_STOP): begin
          if (w_tend) begin
            r_tmr <= '0;
            if (r_byte != 2'd3) begin
              r_byte  <= r_byte + 2'd1;
              r_sh    <= {r_sh[DATA_W-9:0], 8'h00};
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else if (r_addr != A_END) begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_lat   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_addr  <= '0;
              r_state <= S_DONE;
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        (r_state == S_DONE): begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign ram_addr = r_addr;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_result_dump.sv
// tb_result_dump: scoreboard bench for result_dump
// (CLKS_PER_BIT=4, DEPTH=4, RD_LAT=2, word period 162).
module tb_result_dump;

  localparam int C   = 4;
  localparam int D   = 4;
  localparam int L   = 2;
  localparam int WP  = L + 40 * C;
  localparam int DMP = D * WP;

  typedef struct {
    logic [7:0] b;
    int         c;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  ram_addr;
  logic [31:0] ram_q;
  logic        tx;
  logic        busy;
  logic        done;

  logic [7:0]  addr_d1;
  logic [31:0] words [4];

  frame_t exp_q  [$];
  int     done_q [$];
  int     busy_q [$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  result_dump #(
    .CLKS_PER_BIT(C),
    .DEPTH(D),
    .ADDR_W(8),
    .DATA_W(32),
    .RD_LAT(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_addr(ram_addr),
    .ram_q(ram_q),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // RAM model: one register stage plus combinational read = 2 clocks
  always @(posedge clk) addr_d1 <= ram_addr;
  assign ram_q = (addr_d1 < 8'd4) ? words[addr_d1[1:0]] : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n, inout logic ok);
    repeat (n) begin
      @(negedge clk);
      if (!rst) ok = 1'b0;
    end
  endtask

  task automatic push_dump(input int e0);
    frame_t f;
    logic [31:0] w;
    for (int i = 0; i < D; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        f.b = w[31 - 8 * j -: 8];
        f.c = e0 + i * WP + L + j * 10 * C;
        exp_q.push_back(f);
      end
    end
    done_q.push_back(e0 + DMP);
    busy_q.push_back(DMP);
  endtask

  task automatic issue_start(output int e0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    push_dump(e0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_count", n_done, target);
  endtask

  // UART decoder and frame scoreboard
  initial begin : mon_tx
    logic       p;
    logic       ok;
    logic [7:0] d;
    logic       sb;
    int         fall;
    frame_t     e;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && p && !tx) begin
        fall = cyc;
        ok   = 1'b1;
        d    = '0;
        wait_n(C / 2, ok);
        for (int i = 0; i < 8; i++) begin
          wait_n(C, ok);
          d[i] = tx;
        end
        wait_n(C, ok);
        sb = tx;
        if (ok) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(d), 32'(e.b));
            chk("frame_cycle", fall, e.c);
            chk("stop_bit", 32'(sb), 32'd1);
          end
        end
      end
      p = tx;
    end
  end

  // done pulse scoreboard
  always @(negedge clk) begin
    if (rst && done) begin
      n_done++;
      if (done_q.size() == 0) chk("unexpected_done", cyc, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  // busy length scoreboard
  int bcnt = 0;
  always @(negedge clk) begin
    if (!rst) bcnt = 0;
    else if (busy) bcnt++;
    else if (bcnt > 0) begin
      if (busy_q.size() == 0) chk("unexpected_busy", bcnt, 0);
      else chk("busy_len", bcnt, busy_q.pop_front());
      bcnt = 0;
    end
  end

  // address walk: each change must be +1, or 3 -> 0 at the end
  logic [7:0] pa = '0;
  logic       pr = 1'b0;
  always @(negedge clk) begin
    if (rst && pr && ram_addr != pa)
      chk("addr_step", 32'(ram_addr), (pa == 8'd3) ? 32'd0 : 32'(pa) + 1);
    pa = ram_addr;
    pr = rst;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int e0;
    int nd;
    words[0] = 32'hA55A0F01;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    start = 1'b0;
    rst   = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // full dump with a stray start pulse during word 1
    issue_start(e0);
    while (cyc < e0 + WP + 40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("post_addr", 32'(ram_addr), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_tx", 32'(tx), 32'd1);
    chk("post_frames_left", exp_q.size(), 0);

    // reset during data bit 2 of word 2, byte 0 (0x33 -> bit2 = 0)
    issue_start(e0);
    while (cyc < e0 + 2 * WP + L + 3 * C + 1) @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    nd = n_done;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    done_q.delete();
    busy_q.delete();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", n_done, nd);

    // replay from address 0
    issue_start(e0);
    wait_done(nd + 1);
    repeat (3) @(negedge clk);

    // held start: two dumps separated by one IDLE cycle
    nd = n_done;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    push_dump(e0);
    push_dump(e0 + DMP + 2);
    while (cyc < e0 + DMP + 5) @(negedge clk);
    start = 1'b0;
    wait_done(nd + 2);
    repeat (10) @(negedge clk);
    chk("end_frames_left", exp_q.size(), 0);
    chk("end_done_left", done_q.size(), 0);
    chk("end_busy_left", busy_q.size(), 0);
    chk("end_tx", 32'(tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
